axil_bram_port_master: RTL and testbench
========================================

# axil_bram_port_master

AXI4-Lite slave that converts host register-bus transactions into single-beat accesses on the BRAM-style port (addr_a/wrdata_a/en_a/we_a/rddata_a) consumed by the accelerator address decoder. It is the initiator side of that port. It sequences one access at a time, holds read strobes for the buffer read latency, and returns AXI responses, including SLVERR for tags the decoder does not serve. It sits between the PS AXI interconnect and the decoder inside the accelerator top level.

## Interface
- AXI_ADDR_W, 32: AXI byte-address width; bits above 21 are ignored.
- RD_LATENCY, 1: cycles from the read strobe to valid rddata_a. Legal range is 1..4.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- s_axi_awaddr  in  AXI_ADDR_W  write address. s_axi_awvalid in 1, s_axi_awready out 1.
- s_axi_wdata  in  32  write data. s_axi_wstrb in 4. s_axi_wvalid in 1, s_axi_wready out 1.
- s_axi_bresp  out  2  write response. s_axi_bvalid out 1, s_axi_bready in 1.
- s_axi_araddr  in  AXI_ADDR_W  read address. s_axi_arvalid in 1, s_axi_arready out 1.
- s_axi_rdata  out  32  read data. s_axi_rresp out 2. s_axi_rvalid out 1, s_axi_rready in 1.
- addr_a  out  22  byte address to the decoder; bits [1:0] are always 0.
- wrdata_a  out  32  write data.
- en_a  out  1  access strobe.
- we_a  out  4  byte write enables. Bit 0 is the decoder's write/read selector.
- rddata_a  in  32  combinational read data from the decoder.

## Operation
- Tag is byte address bits [21:19]. Write tags are 0, 1 and 2 (SA, FC weight, FC input). Read tags are 3, 4 and 5 (pool addr, FC data, SA data).
- FSM states: IDLE, WR_ISSUE, WR_RESP, RD_HOLD, RD_RESP.
- **Acceptance in IDLE**
  - A write is accepted only when AWVALID and WVALID are both high. AWREADY and WREADY pulse together for one cycle.
  - A read is accepted when ARVALID is high. ARREADY pulses for one cycle.
  - If a write and a read are both pending, priority alternates. A `last_wr` flag grants the opposite of the previous grant. After reset, the write wins first.
  - Address, data and strobe are captured into holding registers on acceptance.
- **Write legality**
  - A write is legal if tag ∈ {0,1,2} and WSTRB[0]=1.
  - Legal write: go to WR_ISSUE.
  - Illegal write: skip the port and go to WR_RESP with BRESP=SLVERR (2'b10). A write with WSTRB[0]=0 must never reach the port, because the decoder would treat it as a read.
- **WR_ISSUE**: one cycle with en_a=1, we_a=WSTRB, addr_a={addr[21:2],2'b00}, wrdata_a=WDATA. Then go to WR_RESP with BRESP=OKAY.
- **WR_RESP**: BVALID=1 until BREADY, then go to IDLE.
- **Read legality**
  - Legal read: tag ∈ {3,4,5}; go to RD_HOLD.
  - Illegal read: go to RD_RESP with RDATA=0 and RRESP=SLVERR.
- **RD_HOLD**
  - en_a=1 and we_a=0 for exactly RD_LATENCY+1 consecutive cycles, with addr_a stable.
  - A down-counter tracks the cycles.
  - rddata_a is registered into RDATA on the final hold cycle, with RRESP=OKAY.
- **RD_RESP**: RVALID=1 until RREADY, then go to IDLE. RDATA and RRESP stay stable while RVALID=1.
- Only one transaction is outstanding at a time. No READY is asserted outside IDLE.
- en_a=0, we_a=0, addr_a=0 and wrdata_a=0 in every state except WR_ISSUE and RD_HOLD.

## Timing
- **Reset**: all READY/VALID outputs are 0. bresp, rresp, rdata, addr_a, wrdata_a, en_a and we_a are 0. State is IDLE and `last_wr`=0.
- **Reset mid-transaction**: the transaction is dropped with no response, and en_a falls in the next cycle.
- **Legal write accepted at cycle T**: en_a is high in T+1, and BVALID is first high in T+2.
- **Legal read accepted at T**:
  - en_a is high in T+1 through T+1+RD_LATENCY.
  - rddata_a is sampled at the end of cycle T+1+RD_LATENCY.
  - RVALID is first high in T+2+RD_LATENCY.
- **Illegal access**: BVALID or RVALID is high at T+1.
- **Back-to-back**: after the B or R handshake in cycle H, the next acceptance happens no earlier than H+1 (IDLE is mandatory).
- **Responses held**: BREADY/RREADY low holds the FSM in its response state indefinitely.

## Structure
- Shared package `accel_addr_pkg`:
  - Tag constants TAG_SA..TAG_SA_DATA_BUF, for reuse with the decoder.
  - `resp_t` (OKAY=2'b00, SLVERR=2'b10).
  - State enum `axil_st_e`.
- No sub-module. The latency counter and arbiter flag are local.

## Test plan
- Write 0x000000A5 to byte address 0x000010, WSTRB=4'hF -> one cycle with en_a=1, we_a=4'hF, addr_a=0x000010, wrdata_a=0xA5; then BRESP=OKAY.
- RD_LATENCY=2; read 0x280004 (tag 5); the decoder model returns 0x3C two cycles after the strobe -> en_a high for 3 cycles at addr_a 0x280004; RDATA=0x0000003C, RRESP=OKAY.
- Write to 0x180000 (tag 3), and separately a write with WSTRB=4'h2 to 0x000000 -> en_a never asserts; both return BRESP=SLVERR.
- Read 0x080000 (tag 1) -> en_a never asserts; RDATA=0, RRESP=SLVERR.
- AW+W and AR raised in the same cycle, for two rounds -> grant order is write, read, write, read, with no overlap on en_a.
- RREADY held low 10 cycles with RVALID=1 -> RDATA stable and no READY asserted; then assert rst during RD_HOLD -> en_a=0 and all VALIDs 0 in the next cycle.

Source files
------------

// File: rtl/accel_addr_pkg.sv
// Shared definitions for the accelerator register port: address tags, AXI
// response codes and the AXI-Lite bridge state encoding.
package accel_addr_pkg;

   // Tag = byte address bits [21:19]
   localparam logic [2:0] TAG_SA          = 3'd0;
   localparam logic [2:0] TAG_FC_WEIGHT   = 3'd1;
   localparam logic [2:0] TAG_FC_INPUT    = 3'd2;
   localparam logic [2:0] TAG_POOL_ADDR   = 3'd3;
   localparam logic [2:0] TAG_FC_DATA     = 3'd4;
   localparam logic [2:0] TAG_SA_DATA_BUF = 3'd5;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_ISSUE = 3'd1,
      WR_RESP  = 3'd2,
      RD_HOLD  = 3'd3,
      RD_RESP  = 3'd4
   } axil_st_e;

   function automatic logic is_wr_tag(input logic [2:0] tag);
      return (tag == TAG_SA) || (tag == TAG_FC_WEIGHT) || (tag == TAG_FC_INPUT);
   endfunction

   function automatic logic is_rd_tag(input logic [2:0] tag);
      return (tag == TAG_POOL_ADDR) || (tag == TAG_FC_DATA) || (tag == TAG_SA_DATA_BUF);
   endfunction

endpackage

// File: rtl/axil_bram_port_master.sv
// AXI4-Lite slave that turns each host access into one single-beat access on
// the decoder's BRAM-style port, one transaction at a time.
module axil_bram_port_master
   import accel_addr_pkg::*;
#(
   parameter int AXI_ADDR_W = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [AXI_ADDR_W-1:0] s_axi_awaddr,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [31:0]           s_axi_wdata,
   input  logic [3:0]            s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [31:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [21:0]           addr_a,
   output logic [31:0]           wrdata_a,
   output logic                  en_a,
   output logic [3:0]            we_a,
   input  logic [31:0]           rddata_a,
   output axil_st_e              o_dbg_state
);

   localparam logic [2:0] LAT_INIT = 3'(RD_LATENCY);

   axil_st_e    r_state;
   logic        r_awready, r_wready, r_arready;
   logic        r_bvalid, r_rvalid;
   resp_t       r_bresp, r_rresp;
   logic [31:0] r_rdata;
   logic [21:0] r_addr_a;
   logic [31:0] r_wrdata_a;
   logic        r_en_a;
   logic [3:0]  r_we_a;
   logic [2:0]  r_cnt;
   logic        r_last_wr;

   logic w_wr_pend, w_rd_pend, w_wr_legal, w_rd_legal;
   logic w_unused_addr_bits;

   assign w_wr_pend  = s_axi_awvalid && s_axi_wvalid;
   assign w_rd_pend  = s_axi_arvalid;
   // A strobe without byte 0 would look like a read to the decoder
   assign w_wr_legal = is_wr_tag(s_axi_awaddr[21:19]) && s_axi_wstrb[0];
   assign w_rd_legal = is_rd_tag(s_axi_araddr[21:19]);
   assign w_unused_addr_bits = ^{s_axi_awaddr[AXI_ADDR_W-1:22], s_axi_awaddr[1:0],
                                 s_axi_araddr[AXI_ADDR_W-1:22], s_axi_araddr[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_awready  <= 1'b0;
         r_wready   <= 1'b0;
         r_arready  <= 1'b0;
         r_bvalid   <= 1'b0;
         r_rvalid   <= 1'b0;
         r_bresp    <= RESP_OKAY;
         r_rresp    <= RESP_OKAY;
         r_rdata    <= 32'd0;
         r_addr_a   <= 22'd0;
         r_wrdata_a <= 32'd0;
         r_en_a     <= 1'b0;
         r_we_a     <= 4'd0;
         r_cnt      <= 3'd0;
         r_last_wr  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_awready) begin
                  r_awready <= 1'b0;
                  r_wready  <= 1'b0;
                  if (w_wr_pend) begin
                     r_last_wr <= 1'b1;
                     if (w_wr_legal) begin
                        r_en_a     <= 1'b1;
                        r_we_a     <= s_axi_wstrb;
                        r_addr_a   <= {s_axi_awaddr[21:2], 2'b00};
                        r_wrdata_a <= s_axi_wdata;
                        r_state    <= WR_ISSUE;
                     end else begin
                        r_bvalid <= 1'b1;
                        r_bresp  <= RESP_SLVERR;
                        r_state  <= WR_RESP;
                     end
                  end
               end else if (r_arready) begin
                  r_arready <= 1'b0;
                  if (w_rd_pend) begin
                     r_last_wr <= 1'b0;
                     if (w_rd_legal) begin
                        r_en_a   <= 1'b1;
                        r_we_a   <= 4'd0;
                        r_addr_a <= {s_axi_araddr[21:2], 2'b00};
                        r_cnt    <= LAT_INIT;
                        r_state  <= RD_HOLD;
                     end else begin
                        r_rvalid <= 1'b1;
                        r_rdata  <= 32'd0;
                        r_rresp  <= RESP_SLVERR;
                        r_state  <= RD_RESP;
                     end
                  end
               end else if (w_wr_pend && (!w_rd_pend || !r_last_wr)) begin
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
               end else if (w_rd_pend) begin
                  r_arready <= 1'b1;
               end
            end
            WR_ISSUE: begin
               r_en_a     <= 1'b0;
               r_we_a     <= 4'd0;
               r_addr_a   <= 22'd0;
               r_wrdata_a <= 32'd0;
               r_bvalid   <= 1'b1;
               r_bresp    <= RESP_OKAY;
               r_state    <= WR_RESP;
            end
            WR_RESP: begin
               if (s_axi_bready) begin
                  r_bvalid <= 1'b0;
                  r_state  <= IDLE;
               end
            end
            RD_HOLD: begin
               // Count reaches zero on the cycle the decoder's data is valid
               if (r_cnt == 3'd0) begin
                  r_rdata  <= rddata_a;
                  r_rresp  <= RESP_OKAY;
                  r_rvalid <= 1'b1;
                  r_en_a   <= 1'b0;
                  r_addr_a <= 22'd0;
                  r_state  <= RD_RESP;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            RD_RESP: begin
               if (s_axi_rready) begin
                  r_rvalid <= 1'b0;
                  r_state  <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign s_axi_awready = r_awready;
   assign s_axi_wready  = r_wready;
   assign s_axi_arready = r_arready;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = r_bresp;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rresp   = r_rresp;
   assign s_axi_rdata   = r_rdata;
   assign addr_a        = r_addr_a;
   assign wrdata_a      = r_wrdata_a;
   assign en_a          = r_en_a;
   assign we_a          = r_we_a;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_axil_bram_port_master.sv
// Bench for axil_bram_port_master: AXI-Lite driver tasks, a latency-accurate
// decoder model and queue-based scoreboards for port accesses and responses.
module tb_axil_bram_port_master;
   import accel_addr_pkg::*;

   localparam int RD_LAT = 2;

   logic        clk, rst;
   logic [31:0] awaddr, wdata, araddr, rdata, wrdata_a, rddata_a;
   logic [3:0]  wstrb, we_a;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, en_a;
   logic [1:0]  bresp, rresp;
   logic [21:0] addr_a;
   axil_st_e    dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [57:0] port_exp_q[$];   // {addr, data, we}
   logic [21:0] rd_addr_q[$];
   logic [1:0]  bresp_q[$];
   logic [33:0] r_exp_q[$];      // {rdata, rresp}
   logic        got_grant[$];    // 1 = write, 0 = read
   logic        arb_mode = 1'b0;

   axil_bram_port_master #(.AXI_ADDR_W(32), .RD_LATENCY(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .addr_a(addr_a), .wrdata_a(wrdata_a), .en_a(en_a), .we_a(we_a), .rddata_a(rddata_a),
      .o_dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [21:0] a);
      if (a == 22'h280004) return 32'h0000_003C;
      return {10'd0, a} ^ 32'hA500_0000;
   endfunction

   // Decoder model: data valid RD_LAT cycles after the strobe, junk otherwise
   logic        pipe_v [RD_LAT];
   logic [21:0] pipe_a [RD_LAT];
   always @(posedge clk) begin
      pipe_v[0] <= !rst && en_a && (we_a == 4'd0);
      pipe_a[0] <= addr_a;
      for (int k = 1; k < RD_LAT; k++) begin
         pipe_v[k] <= rst ? 1'b0 : pipe_v[k-1];
         pipe_a[k] <= pipe_a[k-1];
      end
   end
   assign rddata_a = (pipe_v[RD_LAT-1] === 1'b1) ? model_rd(pipe_a[RD_LAT-1]) : 32'hDEAD_BEEF;

   // Monitor / scoreboard
   int          run_len = 0;
   logic [21:0] prev_addr = '0;
   always @(negedge clk) begin
      if (rst) begin
         run_len <= 0;
      end else begin
         check_val("ready_busy", (awready | wready | arready) & (bvalid | rvalid | en_a), 0);
         check_val("ready_excl", (awready | wready) & arready, 0);
         check_val("port_idle_zero", !en_a && ((addr_a != 0) || (wrdata_a != 0) || (we_a != 0)), 0);
         if (arb_mode && awready && awvalid && wvalid) got_grant.push_back(1'b1);
         if (arb_mode && arready && arvalid) got_grant.push_back(1'b0);
         if (en_a && we_a != 4'd0) begin
            check_val("port_wr_expected", port_exp_q.size() != 0, 1);
            if (port_exp_q.size() != 0)
               check_val("port_wr", {addr_a, wrdata_a, we_a}, port_exp_q.pop_front());
         end
         if (en_a && we_a == 4'd0) begin
            if (run_len == 0) begin
               check_val("port_rd_expected", rd_addr_q.size() != 0, 1);
               if (rd_addr_q.size() != 0) check_val("port_rd_addr", addr_a, rd_addr_q.pop_front());
            end else begin
               check_val("port_rd_addr_stable", addr_a, prev_addr);
            end
            run_len   <= run_len + 1;
            prev_addr <= addr_a;
         end else if (run_len != 0) begin
            check_val("rd_strobe_len", run_len, RD_LAT + 1);
            run_len <= 0;
         end
         if (bvalid && bready) begin
            check_val("bresp_expected", bresp_q.size() != 0, 1);
            if (bresp_q.size() != 0) check_val("bresp", bresp, bresp_q.pop_front());
         end
         if (rvalid && rready) begin
            check_val("rresp_expected", r_exp_q.size() != 0, 1);
            if (r_exp_q.size() != 0) check_val("rdata_rresp", {rdata, rresp}, r_exp_q.pop_front());
         end
      end
   end

   task automatic send_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic legal;
      int   n;
      legal = (addr[21:19] <= 3'd2) && strb[0];
      if (legal) port_exp_q.push_back({addr[21:2], 2'b00, data, strb});
      bresp_q.push_back(legal ? 2'b00 : 2'b10);
      @(posedge clk); #1;
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!(awready && wready) && n < 100);
      check_val("aw_handshake", awready && wready, 1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      check_val("wr_en_t1", en_a, legal);
      if (legal) begin
         check_val("wr_bvalid_t1", bvalid, 0);
         @(negedge clk);
         check_val("wr_bvalid_t2", bvalid, 1);
      end else begin
         check_val("wr_err_bvalid_t1", bvalid, 1);
      end
   endtask

   task automatic send_rd(input logic [31:0] addr);
      logic legal;
      int   n;
      legal = (addr[21:19] >= 3'd3) && (addr[21:19] <= 3'd5);
      if (legal) begin
         rd_addr_q.push_back({addr[21:2], 2'b00});
         r_exp_q.push_back({model_rd({addr[21:2], 2'b00}), 2'b00});
      end else begin
         r_exp_q.push_back({32'd0, 2'b10});
      end
      @(posedge clk); #1;
      araddr = addr; arvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!arready && n < 100);
      check_val("ar_handshake", arready, 1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      if (legal) begin
         repeat (RD_LAT + 1) @(negedge clk);
         check_val("rd_rvalid_early", rvalid, 0);
         @(negedge clk);
         check_val("rd_rvalid_t", rvalid, 1);
      end else begin
         @(negedge clk);
         check_val("rd_err_en", en_a, 0);
         check_val("rd_err_rvalid_t1", rvalid, 1);
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while ((bvalid || rvalid || en_a) && n < 100);
      check_val("drain", bvalid || rvalid || en_a, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, d;
      logic [3:0]  s;
      logic [33:0] held;
      int          n;
      rst = 1'b1;
      awaddr = '0; wdata = '0; wstrb = '0; awvalid = 0; wvalid = 0; bready = 1;
      araddr = '0; arvalid = 0; rready = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_readies", {awready, wready, arready}, 0);
      check_val("rst_valids", {bvalid, rvalid}, 0);
      check_val("rst_resp_data", {bresp, rresp, rdata}, 0);
      check_val("rst_port", {addr_a, wrdata_a, en_a, we_a}, 0);
      check_val("rst_state", dbg_state, IDLE);
      @(posedge clk); #1 rst = 1'b0;

      send_wr(32'h0000_0010, 32'h0000_00A5, 4'hF); wait_done();
      send_rd(32'h0028_0004);                      wait_done();
      send_wr(32'h0018_0000, 32'h1234_5678, 4'hF); wait_done();
      send_wr(32'h0000_0000, 32'h1234_5678, 4'h2); wait_done();
      send_rd(32'h0008_0000);                      wait_done();

      // Simultaneous write and read, two rounds
      arb_mode = 1'b1;
      for (int r = 0; r < 2; r++) begin
         fork
            send_wr(32'h0010_0020 + 32'(r * 4), 32'hC0DE_0000 + 32'(r), 4'hF);
            send_rd(32'h0018_000C + 32'(r * 4));
         join
         wait_done();
      end
      arb_mode = 1'b0;
      check_val("grant_count", got_grant.size(), 4);
      for (int k = 0; k < 4; k++)
         if (k < got_grant.size()) check_val("grant_order", got_grant[k], (k % 2 == 0));

      // Randomised mix of legal and illegal accesses
      for (int i = 0; i < 10; i++) begin
         a = {$urandom_range(0, 1023), 3'($urandom_range(0, 7)), 17'($urandom_range(0, 131071)), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            send_wr(a, d, s);
         end else begin
            send_rd(a);
         end
         wait_done();
      end

      // Response held off while a write is waiting
      rready = 1'b0;
      send_rd(32'h0020_0008);
      held = {model_rd(22'h200008), 2'b00};
      @(posedge clk); #1;
      awaddr = 32'h0000_0040; wdata = 32'h5555_AAAA; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check_val("hold_rvalid", rvalid, 1);
         check_val("hold_rdata", {rdata, rresp}, held);
         check_val("hold_no_ready", {awready, wready, arready}, 0);
      end
      @(posedge clk); #1 rready = 1'b1;
      send_wr(32'h0000_0040, 32'h5555_AAAA, 4'hF); wait_done();

      // Reset in the middle of a read hold
      rd_addr_q.push_back(22'h280010);
      @(posedge clk); #1;
      araddr = 32'h0028_0010; arvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!arready && n < 100);
      check_val("rst_ar_handshake", arready, 1);
      @(posedge clk); #1 arvalid = 1'b0;
      @(negedge clk);
      check_val("rst_hold_en", en_a, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check_val("midrst_en", en_a, 0);
      check_val("midrst_valids", {bvalid, rvalid, awready, wready, arready}, 0);
      check_val("midrst_state", dbg_state, IDLE);
      @(posedge clk); #1 rst = 1'b0;
      repeat (4) @(negedge clk);
      check_val("midrst_no_resp", {bvalid, rvalid, en_a}, 0);

      check_val("queues_empty", port_exp_q.size() + rd_addr_q.size() + bresp_q.size() + r_exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
